// File: rtl/sensor_scan_controller.sv
// Sensor scan controller: walks six multiplexed sensors, settles the mux,
// samples Y and debounces each sensor into a registered occupancy map.
module sensor_scan_controller #(
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Run,
  input  logic [5:0] Mask,
  input  logic       Y,
  output logic [4:0] Selector,
  output logic       Enable,
  output logic [5:0] Occupancy,
  output logic       Change,
  output logic [2:0] ChangeIdx,
  output logic       ScanDone,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  localparam logic [3:0] DB        = 4'(DEBOUNCE);

  state_t          state, state_n;
  logic [2:0]      idx, idx_n;
  logic [3:0]      scnt, scnt_n;
  logic [5:0][2:0] cnt;
  logic [2:0]      lo, up;
  logic [4:0]      sel_n;
  logic            act_n;
  logic            done_n;

  // Lowest unmasked sensor number strictly above 'from'; 0 if none.
  function automatic logic [2:0] first_at(
    input logic [5:0] m,
    input logic [2:0] from
  );
    first_at = 3'd0;
    for (int k = 5; k >= 0; k--)
      if (!m[k] && 3'(k + 1) > from)
        first_at = 3'(k + 1);
  endfunction

  assign lo = first_at(Mask, 3'd0);
  assign up = first_at(Mask, idx);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      scnt  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      scnt  <= scnt_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    scnt_n  = scnt;
    unique case (state)
      S_IDLE: begin
        if (Run && lo != 3'd0) begin
          state_n = S_SELECT;
          idx_n   = lo;
        end
      end
      S_SELECT: begin
        state_n = S_SETTLE;
        scnt_n  = SETTLE_LD;
      end
      S_SETTLE: begin
        scnt_n = scnt - 4'd1;
        if (scnt <= 4'd1)
          state_n = S_SAMPLE;
      end
      S_SAMPLE: state_n = S_NEXT;
      S_NEXT: begin
        if (up != 3'd0) begin
          state_n = S_SELECT;
          idx_n   = up;
        end else if (Run && lo != 3'd0) begin
          state_n = S_SELECT;
          idx_n   = lo;
        end else begin
          state_n = S_IDLE;
          idx_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_comb begin
    sel_n  = {2'b00, idx_n};
    act_n  = (state_n != S_IDLE);
    done_n = (state == S_NEXT) && (up == 3'd0);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Selector <= '0;
      Enable   <= 1'b0;
      Busy     <= 1'b0;
      ScanDone <= 1'b0;
    end else begin
      Selector <= sel_n;
      Enable   <= act_n;
      Busy     <= act_n;
      ScanDone <= done_n;
    end
  end

  // The sensor in progress keeps its counter even if masked mid-slot.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt       <= '0;
      Occupancy <= '0;
      Change    <= 1'b0;
      ChangeIdx <= '0;
    end else begin
      Change <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (state == S_SAMPLE && idx == 3'(k + 1)) begin
          if (Y == Occupancy[k]) begin
            cnt[k] <= '0;
          end else if ({1'b0, cnt[k]} + 4'd1 >= DB) begin
            cnt[k]       <= '0;
            Occupancy[k] <= ~Occupancy[k];
            Change       <= 1'b1;
            ChangeIdx    <= idx;
          end else begin
            cnt[k] <= cnt[k] + 3'd1;
          end
        end else if (Mask[k] &&
                     !(state != S_IDLE && idx == 3'(k + 1))) begin
          cnt[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_scan_controller.sv
// Bench for sensor_scan_controller: directed vector table, async reset
// probes and a randomized run against a slot-timer reference model.
module tb_sensor_scan_controller;

  localparam int ST = 2;
  localparam int DB = 3;

  logic       Clk   = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Run   = 1'b0;
  logic [5:0] Mask  = '0;
  logic       Y     = 1'b0;
  logic [4:0] Selector;
  logic       Enable;
  logic [5:0] Occupancy;
  logic       Change;
  logic [2:0] ChangeIdx;
  logic       ScanDone;
  logic       Busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: current sensor (0 = idle) and position in its slot.
  int         m_sel;
  int         m_phase;
  logic [5:0] m_occ;
  int         m_cnt[6];
  logic       m_change;
  logic       m_done;
  int         m_cidx;

  logic [5:0] ymap  = '0;
  logic       noise = 1'b0;

  typedef struct {
    bit         run;
    logic [5:0] mask;
    logic [5:0] ymap;
    int         cyc;
    int         sel;
    bit         busy;
    int         dones;
    int         chgs;
    logic [5:0] occ;
  } vec_t;

  vec_t tbl[20];

  sensor_scan_controller #(.SETTLE(ST), .DEBOUNCE(DB)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Run       (Run),
    .Mask      (Mask),
    .Y         (Y),
    .Selector  (Selector),
    .Enable    (Enable),
    .Occupancy (Occupancy),
    .Change    (Change),
    .ChangeIdx (ChangeIdx),
    .ScanDone  (ScanDone),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_from(input logic [5:0] m, input int above);
    for (int k = above + 1; k <= 6; k++)
      if (!m[k-1]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_sel    = 0;
    m_phase  = 0;
    m_occ    = '0;
    m_change = 1'b0;
    m_done   = 1'b0;
    m_cidx   = 0;
    for (int k = 0; k < 6; k++) m_cnt[k] = 0;
  endtask

  // Slot = select, ST settle cycles, sample, next: ST+3 cycles per sensor.
  task automatic model_step();
    int old;
    int nx;
    old      = m_sel;
    m_change = 1'b0;
    m_done   = 1'b0;
    if (old != 0 && m_phase == ST + 1) begin
      if (Y != m_occ[old-1]) begin
        m_cnt[old-1]++;
        if (m_cnt[old-1] == DB) begin
          m_cnt[old-1] = 0;
          m_occ[old-1] = ~m_occ[old-1];
          m_change     = 1'b1;
          m_cidx       = old;
        end
      end else begin
        m_cnt[old-1] = 0;
      end
    end
    for (int k = 0; k < 6; k++)
      if (Mask[k] && old != k + 1) m_cnt[k] = 0;
    if (old == 0) begin
      if (Run && lowest_from(Mask, 0) != 0) begin
        m_sel   = lowest_from(Mask, 0);
        m_phase = 0;
      end
    end else if (m_phase == ST + 2) begin
      nx = lowest_from(Mask, old);
      m_phase = 0;
      if (nx != 0) begin
        m_sel = nx;
      end else begin
        m_done = 1'b1;
        m_sel  = Run ? lowest_from(Mask, 0) : 0;
      end
    end else begin
      m_phase++;
    end
  endtask

  task automatic compare();
    check("selector", int'(Selector), m_sel);
    check("enable", int'(Enable), int'(m_sel != 0));
    check("busy", int'(Busy), int'(m_sel != 0));
    check("occupancy", int'(Occupancy), int'(m_occ));
    check("change", int'(Change), int'(m_change));
    check("change_idx", int'(ChangeIdx), m_cidx);
    check("scan_done", int'(ScanDone), int'(m_done));
  endtask

  task automatic drive_y();
    Y = (m_sel != 0) ? (ymap[m_sel-1] ^ noise) : 1'b0;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Rst_n) model_step();
    else model_reset();
    #1 compare();
    drive_y();
  endtask

  task automatic probe_reset(input string name);
    #2 Rst_n = 1'b0;
    model_reset();
    #1 check(name, int'({Selector, Enable, Occupancy, Change,
                         ChangeIdx, ScanDone, Busy}), 0);
  endtask

  initial begin
    int dn;
    int ch;

    tbl = '{
      '{1, 6'h00, 6'h00,  1, 1, 1, 0, 0, 6'h00},
      '{1, 6'h00, 6'h00, 29, 6, 1, 0, 0, 6'h00},
      '{1, 6'h00, 6'h00,  1, 1, 1, 1, 0, 6'h00},
      '{1, 6'h00, 6'h00, 30, 1, 1, 1, 0, 6'h00},
      '{1, 6'h00, 6'h02, 90, 1, 1, 3, 1, 6'h02},
      '{1, 6'h00, 6'h02, 60, 1, 1, 2, 0, 6'h02},
      '{1, 6'h00, 6'h0A, 30, 1, 1, 1, 0, 6'h02},
      '{1, 6'h00, 6'h02, 30, 1, 1, 1, 0, 6'h02},
      '{1, 6'h00, 6'h0A, 60, 1, 1, 2, 0, 6'h02},
      '{1, 6'h00, 6'h0A, 30, 1, 1, 1, 1, 6'h0A},
      '{1, 6'h3D, 6'h0A, 10, 2, 1, 1, 0, 6'h0A},
      '{1, 6'h3D, 6'h0A, 20, 2, 1, 4, 0, 6'h0A},
      '{1, 6'h3F, 6'h0A,  5, 0, 0, 1, 0, 6'h0A},
      '{1, 6'h3F, 6'h0A,  3, 0, 0, 0, 0, 6'h0A},
      '{1, 6'h00, 6'h0A,  1, 1, 1, 0, 0, 6'h0A},
      '{1, 6'h00, 6'h0A, 10, 3, 1, 0, 0, 6'h0A},
      '{0, 6'h00, 6'h0A, 15, 6, 1, 0, 0, 6'h0A},
      '{0, 6'h00, 6'h0A,  5, 0, 0, 1, 0, 6'h0A},
      '{0, 6'h00, 6'h0A,  3, 0, 0, 0, 0, 6'h0A},
      '{1, 6'h00, 6'h0A,  1, 1, 1, 0, 0, 6'h0A}
    };

    model_reset();
    repeat (2) tick();
    Rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      Run  = tbl[i].run;
      Mask = tbl[i].mask;
      ymap = tbl[i].ymap;
      drive_y();
      dn = 0;
      ch = 0;
      repeat (tbl[i].cyc) begin
        tick();
        dn += int'(ScanDone);
        ch += int'(Change);
      end
      check($sformatf("row%0d_sel", i), int'(Selector), tbl[i].sel);
      check($sformatf("row%0d_busy", i), int'(Busy), int'(tbl[i].busy));
      check($sformatf("row%0d_dones", i), dn, tbl[i].dones);
      check($sformatf("row%0d_changes", i), ch, tbl[i].chgs);
      check($sformatf("row%0d_occ", i), int'(Occupancy), int'(tbl[i].occ));
    end

    // Reset in the middle of a settle window, then restart on sensor 3.
    tick();
    probe_reset("async_reset_settle");
    Mask = 6'b000011;
    tick();
    Rst_n = 1'b1;
    tick();
    check("restart_sel", int'(Selector), 3);

    Mask = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) Run = ~Run;
      if ($urandom_range(0, 99) < 2) Mask[$urandom_range(0, 5)] ^= 1'b1;
      if ($urandom_range(0, 99) < 1) Mask = '0;
      if ($urandom_range(0, 99) < 1) ymap[$urandom_range(0, 5)] ^= 1'b1;
      noise = ($urandom_range(0, 5) == 0);
      drive_y();
      if (c == 1500) begin
        probe_reset("async_reset_random");
        tick();
        Rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_scan_controller.md
SENSOR_SCAN_CONTROLLER -- requirements
Module: sensor_scan_controller

Interface
REQ-001 Parameter SETTLE, default 2: cycles Selector/Enable are held before Y is sampled; legal range 1..15.
REQ-002 Parameter DEBOUNCE, default 3: consecutive differing samples needed to flip a sensor's occupancy bit; legal range 1..7.
REQ-003 Clk  input  1  single rising-edge clock for all state.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  level; 1 = scan continuously, 0 = stop after the current pass.
REQ-006 Mask  input  6  bit k-1 = 1 skips sensor k (k = 1..6).
REQ-007 Y  input  1  selected-sensor value returned by the sensor multiplexer.
REQ-008 Selector  output  5  sensor number 1..6 driven to the multiplexer; 0 when idle.
REQ-009 Enable  output  1  multiplexer enable; 1 in every non-IDLE state.
REQ-010 Occupancy  output  6  debounced state; bit k-1 = sensor k.
REQ-011 Change  output  1  one-cycle pulse when any Occupancy bit flips.
REQ-012 ChangeIdx  output  3  sensor number (1..6) of the flip; valid while Change = 1 and held until the next flip.
REQ-013 ScanDone  output  1  one-cycle pulse at the end of each pass.
REQ-014 Busy  output  1  1 in every non-IDLE state.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FSM states SHALL be IDLE, SELECT, SETTLE, SAMPLE and NEXT.
REQ-017 IDLE: if Run = 1 and Mask != 6'b111111, go to SELECT with idx = lowest unmasked sensor; otherwise stay in IDLE.
REQ-018 SELECT: drive Selector = idx and Enable = 1, load the settle counter with SETTLE, then go to SETTLE.
REQ-019 SETTLE: decrement the settle counter each cycle; at 1, go to SAMPLE; Selector is stable throughout.
REQ-020 SAMPLE: capture Y for sensor idx; if Y == Occupancy[idx-1], clear that sensor's counter; otherwise increment it.
REQ-021 When the counter reaches DEBOUNCE, the sensor's Occupancy bit SHALL toggle, its counter SHALL clear, Change SHALL pulse on the following cycle, and ChangeIdx = idx.
REQ-022 Per-sensor counters SHALL be 3 bits wide and SHALL never wrap.
REQ-023 NEXT: select the next unmasked sensor above idx, with Mask sampled in this cycle.
REQ-024 NEXT, no unmasked sensor above idx (end of pass): pulse ScanDone; go to SELECT with the lowest unmasked sensor if Run = 1 and any sensor is unmasked; otherwise go to IDLE.
REQ-025 Per-sensor period SHALL be SETTLE+3 cycles (5 at default); a full 6-sensor pass SHALL take 30 cycles.
REQ-026 Masked sensor: Occupancy bit held and counter cleared while masked.
REQ-027 Run deasserted mid-pass: the pass completes; no abort.
REQ-028 Mask changing mid-pass takes effect at the next NEXT evaluation; the sensor in progress is still sampled.
REQ-029 Only one Occupancy bit SHALL change per cycle; simultaneous changes are impossible by construction.

Reset
REQ-030 While Rst_n = 0, regardless of Clk: state = IDLE, Selector = 0, Enable = 0, Occupancy = 0, Change = 0, ChangeIdx = 0, ScanDone = 0, Busy = 0, all counters = 0.
REQ-031 Reset asserted mid-pass SHALL discard partial debounce progress; after release, scanning restarts from the lowest unmasked sensor.

Verification
REQ-032 Reset: assert Rst_n = 0 mid-SETTLE -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-033 Run = 1, Mask = 0, Y = 0 -> Selector steps 1,2,3,4,5,6, each held 5 cycles; ScanDone every 30 cycles; Change never asserts.
REQ-034 Y = 1 only while Selector = 2 -> in the third pass, Occupancy becomes 6'b000010, Change pulses once with ChangeIdx = 2; no further Change while Y is unchanged.
REQ-035 Y = 1 for sensor 4 in a single pass, then 0 -> no Change; sensor 4's counter returns to 0.
REQ-036 Mask = 6'b111101 -> Selector stays 2, ScanDone every 5 cycles; Mask = 6'b111111 at NEXT -> IDLE, Busy = 0, Selector = 0.
REQ-037 Run dropped while Selector = 3 -> sensors 4..6 are still scanned, ScanDone pulses, then IDLE; Run reasserted -> Selector = 1 after one cycle.
